text_disp_ctrl: RTL
===================

// Module: text_disp_ctrl
// PURPOSE
//  Scheduler between the RSA decrypt core and the VGA text overlay. Feeds a batch of
//  NUM_MSG ciphertext words through the core one at a time and stores each plaintext
//  result in a small buffer. Selects which stored result is shown, and updates the
//  overlay's 32-bit data word and dec_done flag only on frame boundaries so the hex
//  digits never tear mid-frame.
// PARAMETERS
//  NUM_MSG    4        ciphertext words per batch (power of 2, 2..16)
//  TIMEOUT    2**20    max cycles waited for rsa_done before aborting
// PORTS
//  clk          in   1    system clock
//  reset_n      in   1    asynchronous reset, active low
//  go           in   1    1-cycle pulse: start a batch (ignored unless IDLE)
//  ct_idx       out  IW   index into ciphertext source (IW = log2 NUM_MSG)
//  ct_word      in   32   ciphertext at ct_idx (combinational source)
//  rsa_start    out  1    1-cycle start pulse to RSA core
//  rsa_cipher   out  32   ciphertext operand, held stable from rsa_start until rsa_done
//  rsa_done     in   1    1-cycle pulse: rsa_plain valid
//  rsa_plain    in   32   decrypted word
//  frame_tick   in   1    1-cycle pulse at start of vertical blank
//  btn_next     in   1    debounced 1-cycle pulse: show next stored result
//  data         out  32   word displayed as 8 hex digits by the text generator
//  dec_done     out  1    at least one result is shown; gates the text region
//  sel_idx      out  IW   index of the result currently displayed
//  busy         out  1    batch in progress
//  err          out  1    sticky timeout flag, cleared by next go
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; buffer valid bits 0; timeout counter 0.
//  FSM (registered):
//   IDLE  : go -> LOAD; on entry: ct_idx=0, valid bits cleared, err=0, busy=1.
//   LOAD  : rsa_cipher<=ct_word; rsa_start=1 for exactly this one cycle -> WAIT.
//   WAIT  : count cycles; rsa_done -> STORE. Count reaches TIMEOUT-1 without done ->
//           err=1, busy=0 -> IDLE (partial results kept).
//   STORE : buf[ct_idx]<=rsa_plain, valid[ct_idx]<=1. If ct_idx==NUM_MSG-1 -> IDLE,
//           busy=0. Otherwise ct_idx+1 -> LOAD.
//  Latency: rsa_start asserts 1 cycle after go; STORE 1 cycle after rsa_done; the
//   next rsa_start 2 cycles after rsa_done.
//  rsa_done outside WAIT: ignored. go outside IDLE: ignored.
//  Selection: pend_idx is a register. btn_next increments it mod NUM_MSG, skipping to the
//   next valid entry. If none is valid, it is unchanged. btn_next is acted on in any state.
//  Display update: occurs only on the cycle frame_tick=1.
//   - data<=buf[pend_idx], sel_idx<=pend_idx, dec_done<=valid[pend_idx].
//   - Between ticks, data, sel_idx and dec_done hold, even if the buffer or
//     pend_idx change.
//   - When a STORE writes entry pend_idx, the next frame_tick shows the new value.
//  Simultaneous events:
//   - STORE writing entry k and frame_tick selecting k: the old value is shown; the
//     new value appears at the following tick.
//   - btn_next and frame_tick in the same cycle: the tick latches the pre-increment
//     pend_idx.
//  A new go clears valid bits, but the displayed data/dec_done persist until the next
//   frame_tick. At that tick, dec_done falls to 0 unless the entry has been rewritten.
//  Reset asserted mid-batch: immediate return to reset values. The RSA core sees no
//   further rsa_start.
//  Timeout counter: $clog2(TIMEOUT) bits; saturates; cleared on entry to WAIT.
// STRUCTURE
//  Shared package (rsa_disp_pkg): state encoding IDLE/LOAD/WAIT/STORE, DATA_W=32,
//   HEX_DIGITS=8.
//  Sub-module disp_result_buf: NUM_MSG x 32 register file with per-entry valid bits,
//   one write port, one async read port, and a clear_valid input.
//  Top level holds: FSM, timeout counter, selection logic and frame-synchronous output
//   registers.
// TESTING
//  1 Reset: assert reset_n=0 mid-WAIT -> all outputs 0, no rsa_start for 100 cycles
//    after release.
//  2 Batch: go, model core returns ct^32'h5A5A5A5A after 50 cycles for 4 words ->
//    4 rsa_start pulses, busy low 1 cycle after 4th STORE. First frame_tick after the
//    first STORE gives data=buf[0], dec_done=1.
//  3 Tear-free: frame_tick every 1000 cycles, btn_next mid-frame -> data/sel_idx change
//    only on the tick cycle. sel_idx sequence 0,1,2,3,0 across 5 presses+ticks.
//  4 Timeout: TIMEOUT=64, core never answers -> err=1 at 64th WAIT cycle, state IDLE,
//    busy=0. Next go clears err.
//  5 Collisions: STORE to entry 0 and frame_tick in same cycle -> old data shown, new
//    data at next tick. btn_next with tick -> old sel_idx latched.
//  6 Skip invalid: only entries 0,1 valid (timeout on 2), btn_next from 1 -> sel_idx 0.
//    Spurious rsa_done in IDLE -> buffer unchanged.

Source files
------------

// File: rtl/text_disp_ctrl_pkg.sv
// Shared types and constants for the RSA-to-text-overlay scheduler.
package text_disp_ctrl_pkg;

  // One hex digit per nibble of the displayed word.
  localparam int unsigned HEX_DIGITS = 8;
  localparam int unsigned DATA_W     = HEX_DIGITS * 4;

  // Batch scheduler states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StWait  = 2'd2,
    StStore = 2'd3
  } state_e;

endpackage

// File: rtl/text_disp_ctrl_result_buf.sv
// Plaintext result store: NUM_MSG words, per-entry valid bits, one write port,
// one asynchronous read port and a bulk valid clear.
module text_disp_ctrl_result_buf
  import text_disp_ctrl_pkg::*;
#(
  parameter int unsigned NUM_MSG = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_we,
  input  logic [$clog2(NUM_MSG)-1:0] i_waddr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_clear_valid,
  input  logic [$clog2(NUM_MSG)-1:0] i_raddr,
  output logic [DATA_W-1:0]          o_rdata,
  output logic [NUM_MSG-1:0]         o_valid
);

  logic [DATA_W-1:0]  r_mem [NUM_MSG];
  logic [NUM_MSG-1:0] r_valid;

  // Data words: written only by the STORE state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NUM_MSG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Valid bits: a batch start wipes them; data words are left in place.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= '0;
    end else if (i_clear_valid) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_valid = r_valid;

endmodule

// File: rtl/text_disp_ctrl.sv
// Batch scheduler between the RSA decrypt core and the VGA text overlay.
// Runs NUM_MSG ciphertexts through the core, buffers the plaintexts and
// refreshes the displayed word only on frame boundaries.
module text_disp_ctrl
  import text_disp_ctrl_pkg::*;
#(
  parameter int unsigned NUM_MSG = 4,
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_go,
  output logic [$clog2(NUM_MSG)-1:0] o_ct_idx,
  input  logic [DATA_W-1:0]          i_ct_word,
  output logic                       o_rsa_start,
  output logic [DATA_W-1:0]          o_rsa_cipher,
  input  logic                       i_rsa_done,
  input  logic [DATA_W-1:0]          i_rsa_plain,
  input  logic                       i_frame_tick,
  input  logic                       i_btn_next,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_dec_done,
  output logic [$clog2(NUM_MSG)-1:0] o_sel_idx,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int unsigned IW = $clog2(NUM_MSG);
  localparam int unsigned TW = $clog2(TIMEOUT);

  // FSM and datapath registers
  state_e            r_state;
  logic [IW-1:0]     r_ct_idx;
  logic              r_rsa_start;
  logic [DATA_W-1:0] r_cipher;
  logic [DATA_W-1:0] r_plain;
  logic              r_busy;
  logic              r_err;
  logic [TW-1:0]     r_tmo_cnt;

  // Selection and frame-synchronous display registers
  logic [IW-1:0]     r_pend_idx;
  logic [DATA_W-1:0] r_data;
  logic [IW-1:0]     r_sel_idx;
  logic              r_dec_done;

  // Buffer interface
  logic               w_buf_we;
  logic               w_clear_valid;
  logic [DATA_W-1:0]  w_rdata;
  logic [NUM_MSG-1:0] w_valid;

  // Next-valid search for btn_next
  logic               w_found;
  logic [IW-1:0]      w_next_idx;
  logic [IW-1:0]      w_cand;

  assign w_buf_we      = (r_state == StStore);
  assign w_clear_valid = (r_state == StIdle) && i_go;

  text_disp_ctrl_result_buf #(
    .NUM_MSG (NUM_MSG)
  ) u_result_buf (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_we          (w_buf_we),
    .i_waddr       (r_ct_idx),
    .i_wdata       (r_plain),
    .i_clear_valid (w_clear_valid),
    .i_raddr       (r_pend_idx),
    .o_rdata       (w_rdata),
    .o_valid       (w_valid)
  );

  // Batch FSM: LOAD issues the start pulse, WAIT counts toward timeout,
  // STORE commits the captured plaintext and advances the index.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_ct_idx    <= '0;
      r_rsa_start <= 1'b0;
      r_cipher    <= '0;
      r_plain     <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_rsa_start <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_go) begin
            r_state     <= StLoad;
            r_ct_idx    <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_rsa_start <= 1'b1;
          end
        end
        StLoad: begin
          r_cipher  <= i_ct_word;
          r_tmo_cnt <= '0;
          r_state   <= StWait;
        end
        StWait: begin
          // A response in the final counted cycle still wins over the timeout.
          if (i_rsa_done) begin
            r_plain <= i_rsa_plain;
            r_state <= StStore;
          end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (r_tmo_cnt != '1) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        StStore: begin
          if (r_ct_idx == IW'(NUM_MSG - 1)) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_ct_idx    <= r_ct_idx + 1'b1;
            r_rsa_start <= 1'b1;
            r_state     <= StLoad;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Find the next valid entry after pend_idx, wrapping; pend_idx itself is last.
  always_comb begin
    w_found    = 1'b0;
    w_next_idx = r_pend_idx;
    w_cand     = '0;
    for (int unsigned k = 1; k <= NUM_MSG; k++) begin
      w_cand = r_pend_idx + IW'(k);
      if (!w_found && w_valid[w_cand]) begin
        w_found    = 1'b1;
        w_next_idx = w_cand;
      end
    end
  end

  // Pending selection: advanced by btn_next in any FSM state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend_idx <= '0;
    end else if (i_btn_next && w_found) begin
      r_pend_idx <= w_next_idx;
    end
  end

  // Display registers: sample the pre-edge buffer and pend_idx on frame_tick only,
  // so a same-cycle STORE or btn_next shows up one frame later.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data     <= '0;
      r_sel_idx  <= '0;
      r_dec_done <= 1'b0;
    end else if (i_frame_tick) begin
      r_data     <= w_rdata;
      r_sel_idx  <= r_pend_idx;
      r_dec_done <= w_valid[r_pend_idx];
    end
  end

  // Operand is live from ct_word during the start pulse, then held from the register.
  assign o_rsa_cipher = (r_state == StLoad) ? i_ct_word : r_cipher;
  assign o_ct_idx     = r_ct_idx;
  assign o_rsa_start  = r_rsa_start;
  assign o_busy       = r_busy;
  assign o_err        = r_err;
  assign o_data       = r_data;
  assign o_sel_idx    = r_sel_idx;
  assign o_dec_done   = r_dec_done;

endmodule
